// File: rtl/series_pkg.sv
// Shared types and Q-format helpers for the series evaluator.
// State encoding, saturation and reciprocal-table construction.
package series_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACC,
    S_MUL_X,
    S_MUL_C,
    S_DONE
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 12;
  localparam int DEF_TERMS = 8;

  function automatic longint one_q(input int frac);
    return longint'(1) << frac;
  endfunction

  function automatic longint max_w(input int width);
    return (longint'(1) << (width - 1)) - 1;
  endfunction

  function automatic longint min_w(input int width);
    return -(longint'(1) << (width - 1));
  endfunction

  function automatic longint sat_w(input longint v,
                                   input int width);
    if (v > max_w(width)) return max_w(width);
    if (v < min_w(width)) return min_w(width);
    return v;
  endfunction

  // floor(ONE/k); k = 0 is never used and reads as 0.
  function automatic longint recip_q(input int k,
                                     input int frac,
                                     input int width);
    longint r;
    if (k <= 0) return 0;
    r = one_q(frac) / k;
    if (r > max_w(width)) r = max_w(width);
    return r;
  endfunction

endpackage

// File: rtl/series_recip_rom.sv
// Combinational reciprocal table recip(k) = floor(ONE/k).
// Ports: k (term index), recip (Q-format reciprocal, 0 for k = 0).
module series_recip_rom
  import series_pkg::*;
#(
  parameter int TERMS = DEF_TERMS,
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int CW    = $clog2(TERMS + 1)
) (
  input  logic [CW-1:0]    k,
  output logic [WIDTH-1:0] recip
);

  logic [WIDTH-1:0] rom [TERMS];

  for (genvar i = 0; i < TERMS; i++) begin : g_rom
    assign rom[i] = WIDTH'(recip_q(i, FRAC, WIDTH));
  end

  always_comb begin
    recip = '0;
    for (int i = 0; i < TERMS; i++) begin
      if (k == CW'(i)) recip = rom[i];
    end
  end

endmodule

// File: rtl/series_eval_unit.sv
// Iterative evaluator of sum s_k*x^k/k!, k = 0..n-1, saturating.
// Ports: clk/rst, start/x_in/n_terms/alt in; ready/busy/done/result/ovf out.
module series_eval_unit
  import series_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int TERMS = DEF_TERMS,
  parameter int CW    = $clog2(TERMS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic [CW-1:0]           n_terms,
  input  logic                    alt,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] result,
  output logic                    ovf
);

  localparam logic signed [WIDTH-1:0] ONE =
    WIDTH'(one_q(FRAC));

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] x_q;
  logic signed [WIDTH-1:0] term_q;
  logic signed [WIDTH-1:0] acc_q;
  logic [CW-1:0]           k_q;
  logic [CW-1:0]           n_q;
  logic                    alt_q;

  logic [WIDTH-1:0]          recip;
  logic signed [WIDTH-1:0]   mul_op;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] prod_sh;
  longint                    prod_l;
  longint                    prod_s;
  logic signed [WIDTH-1:0]   mul_sat;
  logic                      mul_ovf;

  logic signed [WIDTH:0]     addend;
  logic signed [WIDTH:0]     sum;
  longint                    sum_l;
  longint                    sum_s;
  logic signed [WIDTH-1:0]   add_sat;
  logic                      add_ovf;

  logic [CW-1:0]             k_nxt;
  logic [CW-1:0]             n_clamp;

  series_recip_rom #(
    .TERMS(TERMS),
    .WIDTH(WIDTH),
    .FRAC (FRAC),
    .CW   (CW)
  ) u_rom (
    .k    (k_q),
    .recip(recip)
  );

  // One shared multiplier: x in MUL_X, recip(k) in MUL_C.
  assign mul_op  = (state == S_MUL_C) ? signed'(recip) : x_q;
  assign prod    = (2*WIDTH)'(mul_op) * (2*WIDTH)'(term_q);
  assign prod_sh = prod >>> FRAC;
  assign prod_l  = longint'(prod_sh);
  assign prod_s  = sat_w(prod_l, WIDTH);
  assign mul_sat = WIDTH'(prod_s);
  assign mul_ovf = (prod_s != prod_l);

  assign addend  = (alt_q & k_q[0])
                 ? -((WIDTH+1)'(term_q))
                 : (WIDTH+1)'(term_q);
  assign sum     = (WIDTH+1)'(acc_q) + addend;
  assign sum_l   = longint'(sum);
  assign sum_s   = sat_w(sum_l, WIDTH);
  assign add_sat = WIDTH'(sum_s);
  assign add_ovf = (sum_s != sum_l);

  assign k_nxt   = k_q + CW'(1);
  assign n_clamp = (n_terms > CW'(TERMS)) ? CW'(TERMS) : n_terms;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = (n_q == '0) ? S_DONE : S_ACC;
      S_ACC:   state_nxt = (k_nxt == n_q || term_q == '0)
                         ? S_DONE : S_MUL_X;
      S_MUL_X: state_nxt = S_MUL_C;
      S_MUL_C: state_nxt = S_ACC;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == S_IDLE);
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
  end

  // result is written on the edge into DONE so it is valid with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      term_q <= '0;
      acc_q  <= '0;
      k_q    <= '0;
      n_q    <= '0;
      alt_q  <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            x_q   <= x_in;
            alt_q <= alt;
            n_q   <= n_clamp;
          end
        end
        S_LOAD: begin
          term_q <= ONE;
          acc_q  <= '0;
          k_q    <= '0;
          ovf    <= 1'b0;
          result <= '0;
        end
        S_ACC: begin
          acc_q <= add_sat;
          k_q   <= k_nxt;
          if (add_ovf) ovf <= 1'b1;
          if (state_nxt == S_DONE) result <= add_sat;
        end
        S_MUL_X, S_MUL_C: begin
          term_q <= mul_sat;
          if (mul_ovf) ovf <= 1'b1;
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_series_eval_unit.sv
// Scoreboard bench for series_eval_unit (WIDTH=16, FRAC=12, TERMS=8).
// Expected result/ovf/latency come from a behavioural series model.
module tb_series_eval_unit;

  localparam int W  = 16;
  localparam int F  = 12;
  localparam int T  = 8;
  localparam int CW = $clog2(T + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic signed [W-1:0] x_in = '0;
  logic [CW-1:0]       n_terms = '0;
  logic                alt = 1'b0;
  logic                ready, busy, done, ovf;
  logic signed [W-1:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint res;
    bit     ov;
    int     cyc;
  } exp_t;

  exp_t sb[$];

  series_eval_unit #(.WIDTH(W), .FRAC(F), .TERMS(T)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x_in   (x_in),
    .n_terms(n_terms),
    .alt    (alt),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint msat(input longint v, inout bit ov);
    if (v > 32767)  begin ov = 1; return 32767;  end
    if (v < -32768) begin ov = 1; return -32768; end
    return v;
  endfunction

  // Straight-line series: term_{k+1} = term_k * x / (k+1) in Q4.12.
  function automatic exp_t model(input longint x, input int n,
                                 input bit a);
    exp_t   e;
    longint term = 4096;
    longint acc  = 0;
    int     nn   = (n > T) ? T : n;
    e.ov  = 0;
    e.res = 0;
    e.cyc = 2;
    if (nn == 0) return e;
    for (int k = 0; k < T; k++) begin
      acc = msat(acc + ((a && (k % 2 == 1)) ? -term : term), e.ov);
      if (k + 1 == nn || term == 0) begin
        e.res = acc;
        e.cyc = 3 * k + 3;
        break;
      end
      term = msat((term * x) >>> F, e.ov);
      term = msat((term * (4096 / (k + 1))) >>> F, e.ov);
    end
    return e;
  endfunction

  task automatic run_op(input string tag, input int x, input int n,
                        input bit a, input bit poke);
    int   cyc;
    int   w;
    exp_t e;
    exp_t got;
    w = 0;
    @(negedge clk);
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_ready"}, ready, 1);
    start   = 1'b1;
    x_in    = W'(x);
    n_terms = CW'(n);
    alt     = a;
    sb.push_back(model(x, n, a));
    @(posedge clk);
    #1;
    start = 1'b0;
    x_in  = '0;
    cyc   = 1;
    chk({tag, "_busy"}, busy, 1);
    while (!done && cyc < 60) begin
      if (poke && cyc == 3) begin
        start   = 1'b1;
        x_in    = 16'sd8192;
        n_terms = CW'(2);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    if (!done) begin
      chk({tag, "_timeout"}, 0, 1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      got.res = longint'(result);
      chk({tag, "_result"}, got.res, e.res);
      chk({tag, "_ovf"}, ovf, e.ov);
      chk({tag, "_cycle"}, cyc, e.cyc);
    end
    if (poke) begin
      int extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        #1;
        if (done) extra++;
      end
      chk({tag, "_no_second_done"}, extra, 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    run_op("x0_n5", 0, 5, 0, 0);
    run_op("x1_n3", 4096, 3, 0, 0);
    run_op("x1_n3_alt", 4096, 3, 1, 0);
    run_op("x7_sat", 28672, 4, 0, 0);
    run_op("ovf_clear", 0, 3, 0, 0);
    run_op("n0", 4096, 0, 0, 0);
    run_op("n15_clamp", 4096, 15, 0, 0);
    run_op("neg_x", -4096, 6, 0, 0);
    run_op("neg_alt", -8192, 8, 1, 0);
    run_op("x7_alt", 28672, 5, 1, 0);
    run_op("busy_start", 4096, 3, 0, 1);
    for (int i = 0; i < 6; i++) begin
      run_op("rand", int'($urandom_range(16384)) - 8192,
             int'($urandom_range(9)), 1'($urandom_range(1)), 0);
    end

    // Abort in MUL_X: start accepted, LOAD, ACC, then MUL_X.
    @(negedge clk);
    start   = 1'b1;
    x_in    = 16'sd4096;
    n_terms = CW'(5);
    alt     = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_ovf", ovf, 0);
    begin
      int extra = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (done) extra++;
      end
      chk("abort_no_done", extra, 0);
    end

    run_op("after_abort", 4096, 3, 1, 0);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
